// File: rtl/cam_frame_ctrl.sv
// Camera frame capture controller.
// Pulls {vsync, href, byte} words from a camera FIFO (one-cycle read latency),
// waits for a frame boundary, pairs bytes into RGB565 pixels and writes them
// into a line-major frame buffer. Tracks FIFO overflow while capturing.
module cam_frame_ctrl #(
    parameter int H_PIX   = 160,
    parameter int V_LINES = 120,
    parameter int ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [9:0]        fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic              fifo_rd,
    output logic              capture,
    output logic [15:0]       px_data,
    output logic [ADDR_W-1:0] px_addr,
    output logic              px_we,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int COL_W  = $clog2(H_PIX + 1);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [COL_W-1:0]  H_COL  = COL_W'(H_PIX);
    localparam logic [LINE_W-1:0] V_LAST = LINE_W'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SYNC,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                word_valid_q, word_valid_d;
    logic                phase_q, phase_d;
    logic                seen_href_q, seen_href_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [15:0]         px_data_q, px_data_d;
    logic [ADDR_W-1:0]   px_addr_q, px_addr_d;
    logic                px_we_q, px_we_d;
    logic                capture_q, capture_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                process_word;

    logic       w_vsync;
    logic       w_href;
    logic [7:0] w_byte;

    assign w_vsync = fifo_data[9];
    assign w_href  = fifo_data[8];
    assign w_byte  = fifo_data[7:0];

    // Read strobe: only in reading states, never on an empty FIFO, never two cycles in a row.
    // Because a word is being consumed whenever word_valid_q is set, no read is issued in
    // the cycle that may end the frame, so no word is lost on the way to DONE.
    assign fifo_rd = !reset && !fifo_empty && !word_valid_q &&
                     ((state_q == S_ARM) || (state_q == S_SYNC) || (state_q == S_ACTIVE));

    assign capture = capture_q;
    assign px_data = px_data_q;
    assign px_addr = px_addr_q;
    assign px_we   = px_we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

    // Next-state, counter and output computation.
    always_comb begin
        state_d      = state_q;
        word_valid_d = fifo_rd;
        phase_d      = phase_q;
        seen_href_d  = seen_href_q;
        col_d        = col_q;
        line_d       = line_q;
        line_base_d  = line_base_q;
        px_data_d    = px_data_q;
        px_addr_d    = px_addr_q;
        px_we_d      = 1'b0;
        ovf_d        = ovf_q | (capture_q & fifo_full);
        process_word = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ARM;
                    ovf_d       = 1'b0;
                    phase_d     = 1'b0;
                    seen_href_d = 1'b0;
                    col_d       = '0;
                    line_d      = '0;
                    line_base_d = '0;
                end
            end
            S_ARM: begin
                if (word_valid_q && w_vsync) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                // The first word after vsync drops is already frame data.
                if (word_valid_q && !w_vsync) begin
                    state_d      = S_ACTIVE;
                    process_word = 1'b1;
                end
            end
            S_ACTIVE: begin
                process_word = word_valid_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (process_word) begin
            if (w_vsync) begin
                state_d = S_DONE;
            end else if (w_href) begin
                seen_href_d = 1'b1;
                phase_d     = ~phase_q;
                if (!phase_q) begin
                    px_data_d[15:8] = w_byte;
                end else begin
                    px_data_d[7:0] = w_byte;
                    // Pixels beyond the stored width are dropped; col parks at H_PIX.
                    if (col_q < H_COL) begin
                        px_we_d   = 1'b1;
                        px_addr_d = line_base_q + ADDR_W'(col_q);
                        col_d     = col_q + 1'b1;
                    end
                end
            end else if (seen_href_q) begin
                // Line end: an odd trailing byte is simply forgotten by clearing phase.
                seen_href_d = 1'b0;
                phase_d     = 1'b0;
                col_d       = '0;
                line_d      = line_q + 1'b1;
                line_base_d = line_base_q + H_STEP;
                if (line_q + 1'b1 == V_LAST) begin
                    state_d = S_DONE;
                end
            end
        end

        capture_d = (state_d == S_ARM) || (state_d == S_SYNC) || (state_d == S_ACTIVE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and registered outputs; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_valid_q <= 1'b0;
            phase_q      <= 1'b0;
            seen_href_q  <= 1'b0;
            col_q        <= '0;
            line_q       <= '0;
            line_base_q  <= '0;
            px_data_q    <= '0;
            px_addr_q    <= '0;
            px_we_q      <= 1'b0;
            capture_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_valid_q <= word_valid_d;
            phase_q      <= phase_d;
            seen_href_q  <= seen_href_d;
            col_q        <= col_d;
            line_q       <= line_d;
            line_base_q  <= line_base_d;
            px_data_q    <= px_data_d;
            px_addr_q    <= px_addr_d;
            px_we_q      <= px_we_d;
            capture_q    <= capture_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cam_frame_ctrl.sv
// Self-checking bench for cam_frame_ctrl using a small frame geometry.
// A behavioural model turns each frame's word stream into the expected list
// of frame-buffer writes; the DUT's writes are collected and compared.
module tb_cam_frame_ctrl;

    localparam int H_T = 8;
    localparam int V_T = 6;
    localparam int AW  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [9:0]    fifo_data;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_rd;
    logic          capture;
    logic [15:0]   px_data;
    logic [AW-1:0] px_addr;
    logic          px_we;
    logic          busy;
    logic          done;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic [9:0]     fw[$];      // frame word stream under construction
    logic [9:0]     pend[$];    // words not yet placed in the FIFO
    logic [9:0]     q[$];       // FIFO contents
    logic [AW+15:0] got[$];     // DUT writes {addr, data}
    logic [AW+15:0] exp_w[$];   // model writes {addr, data}
    int             done_seen;
    bit             rd_last;
    bit             rd_prev;
    bit             exp_ovf;

    cam_frame_ctrl #(
        .H_PIX  (H_T),
        .V_LINES(V_T),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_rd   (fifo_rd),
        .capture   (capture),
        .px_data   (px_data),
        .px_addr   (px_addr),
        .px_we     (px_we),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: serve last read, observe outputs, feed FIFO, then check the read strobe.
    task automatic step();
        @(negedge clk);
        if (rd_last) fifo_data = q.pop_front();
        if (px_we) got.push_back({px_addr, px_data});
        if (done) done_seen++;
        if (pend.size() > 0 && $urandom_range(0, 2) != 0) q.push_back(pend.pop_front());
        fifo_empty = (q.size() == 0);
        #1;
        rd_prev = rd_last;
        rd_last = fifo_rd;
        if (fifo_rd) chk("rd_guard{empty,prev_rd}", {30'd0, fifo_empty, rd_prev}, 32'd0);
    endtask

    // Frame semantics: wait for vsync high, then for vsync low; collect href bytes per
    // line; each line contributes min(bytes/2, H) pixels at line*H + k.
    task automatic model(output int used);
        int         st;
        int         line;
        bit         fin;
        logic [7:0] lb[$];
        st = 0; line = 0; fin = 0;
        used = fw.size();
        exp_w.delete();
        for (int i = 0; i < fw.size() && !fin; i++) begin
            if (st == 0) begin
                if (fw[i][9]) st = 1;
            end else if (st == 1 && fw[i][9]) begin
                st = 1;
            end else begin
                st = 2;
                if (fw[i][9]) begin
                    used = i + 1; fin = 1;
                end else if (fw[i][8]) begin
                    lb.push_back(fw[i][7:0]);
                end else if (lb.size() > 0) begin
                    for (int k = 0; k < lb.size() / 2 && k < H_T; k++)
                        exp_w.push_back({AW'(line * H_T + k), lb[2*k], lb[2*k+1]});
                    line++;
                    lb.delete();
                    if (line == V_T) begin
                        used = i + 1; fin = 1;
                    end
                end
            end
        end
    endtask

    task automatic gen_random();
        int nl;
        fw.delete();
        for (int i = 0; i < $urandom_range(0, 3); i++)
            fw.push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
        for (int i = 0; i < $urandom_range(1, 2); i++)
            fw.push_back({2'b10, 8'($urandom)});
        nl = $urandom_range(1, V_T);
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < $urandom_range(0, 2 * H_T + 3); b++)
                fw.push_back({2'b01, 8'($urandom)});
            for (int e = 0; e < $urandom_range(1, 2); e++)
                fw.push_back({2'b00, 8'($urandom)});
        end
        fw.push_back({2'b10, 8'($urandom)});
    endtask

    // Start a frame from IDLE, stream it, wait for done and compare writes.
    task automatic run_frame(input string tag, input int mid_start, input int full_at);
        int used;
        model(used);
        pend.delete();
        for (int i = 0; i < used; i++) pend.push_back(fw[i]);
        got.delete();
        done_seen = 0;
        exp_ovf   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_capture_on"}, {31'd0, capture}, 32'd1);
        chk({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ovf_cleared"}, {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 5000; i++) begin
            step();
            if (done_seen > 0) break;
            start     = (i == mid_start) && busy;
            fifo_full = (i == full_at);
            if (fifo_full && capture) exp_ovf = 1;
        end
        start     = 1'b0;
        fifo_full = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_capture_at_done"}, {31'd0, capture}, 32'd0);
        step();
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
        step();
        chk({tag, "_done_once"}, 32'(done_seen), 32'd1);
        chk({tag, "_nwrites"}, 32'(got.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(exp_w[i]));
        chk({tag, "_consumed"}, 32'(q.size() + pend.size()), 32'd0);
        chk({tag, "_ovf_end"}, {31'd0, ovf}, {31'd0, exp_ovf});
        $display("frame %s: words=%0d writes=%0d ovf=%0b", tag, used, got.size(), ovf);
    endtask

    task automatic frame_r34();
        fw = '{10'h200, 10'h112, 10'h134, 10'h156, 10'h178, 10'h000,
               10'h112, 10'h134, 10'h156, 10'h178, 10'h000, 10'h200};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        rd_last = 0; rd_prev = 0; done_seen = 0;
        step();
        step();
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_capture", {31'd0, capture}, 32'd0);
        chk("rst_px_data", {16'd0, px_data}, 32'd0);
        chk("rst_px_addr", 32'(px_addr), 32'd0);
        chk("rst_px_we", {31'd0, px_we}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        reset = 1'b0;

        // fifo_full while idle is not an overflow (capture is low).
        fifo_full = 1'b1;
        step();
        fifo_full = 1'b0;
        step();
        chk("ovf_idle", {31'd0, ovf}, 32'd0);

        frame_r34();
        run_frame("r34", -1, -1);
        chk("r34_a0", 32'(got[0]), 32'({6'd0, 16'h1234}));
        chk("r34_a1", 32'(got[1]), 32'({6'd1, 16'h5678}));
        chk("r34_a2", 32'(got[2]), 32'({6'd8, 16'h1234}));
        chk("r34_a3", 32'(got[3]), 32'({6'd9, 16'h5678}));

        fw.delete();
        fw.push_back(10'h200);
        for (int i = 0; i < 2 * H_T + 4; i++) fw.push_back({2'b01, 8'(i)});
        fw.push_back(10'h000);
        fw.push_back(10'h1AA); fw.push_back(10'h1BB); fw.push_back(10'h000);
        fw.push_back(10'h200);
        run_frame("longline", -1, -1);
        chk("longline_cnt", 32'(got.size()), 32'(H_T + 1));
        chk("longline_last0", 32'(got[H_T-1]), 32'({6'd7, 16'h0e0f}));
        chk("longline_next", 32'(got[H_T]), 32'({6'd8, 16'hAABB}));

        fw.delete();
        fw.push_back(10'h200);
        for (int l = 0; l < V_T; l++) begin
            for (int b = 0; b < 2 * H_T; b++) fw.push_back({2'b01, 8'(l * 16 + b)});
            fw.push_back(10'h000);
        end
        run_frame("full", -1, -1);
        chk("full_cnt", 32'(got.size()), 32'(H_T * V_T));
        chk("full_last_addr", 32'(got[H_T*V_T-1][AW+15:16]), 32'(H_T * V_T - 1));

        for (int f = 0; f < 6; f++) begin
            gen_random();
            run_frame($sformatf("rnd%0d", f), (f % 2 == 1) ? 25 : -1, (f == 2) ? 15 : -1);
        end

        // Reset in the middle of a frame: no done, everything zero, clean restart.
        frame_r34();
        pend.delete();
        foreach (fw[i]) pend.push_back(fw[i]);
        got.delete();
        done_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2000 && got.size() < 2; i++) step();
        chk("midrst_reached_active", {31'd0, (got.size() >= 2)}, 32'd1);
        reset = 1'b1;
        step();
        chk("midrst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("midrst_capture", {31'd0, capture}, 32'd0);
        chk("midrst_px_data", {16'd0, px_data}, 32'd0);
        chk("midrst_px_addr", 32'(px_addr), 32'd0);
        chk("midrst_px_we", {31'd0, px_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        reset = 1'b0;
        pend.delete();
        q.delete();
        rd_last = 0;
        fifo_empty = 1'b1;
        repeat (5) step();
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        $display("frame midrst: abandoned after %0d writes", got.size());

        frame_r34();
        run_frame("after_rst", -1, -1);
        chk("after_rst_a0", 32'(got[0]), 32'({6'd0, 16'h1234}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
